// File: rtl/sort_circuit_pkg.sv
// Shared definitions for the sort circuit and its companion memory model.
// Holds the FSM state encoding, bus response codes and default widths.
package sort_circuit_pkg;

  localparam int unsigned DEF_ADDR_WDTH = 4;
  localparam int unsigned DEF_DATA_WDTH = 32;
  localparam int unsigned DEF_RESP_WDTH = 1;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StRdA     = 4'd1,
    StRdAWait = 4'd2,
    StRdB     = 4'd3,
    StRdBWait = 4'd4,
    StCmp     = 4'd5,
    StWrA     = 4'd6,
    StWrAResp = 4'd7,
    StWrB     = 4'd8,
    StWrBResp = 4'd9,
    StNext    = 4'd10,
    StFin     = 4'd11
  } state_e;

endpackage

// File: rtl/sort_circuit_mem.sv
// Behavioral slave memory used to exercise sort_circuit.
// Ports mirror the sort_circuit bus (read address/data, write address+data,
// write response) plus always_success / always_error response overrides.
// 2**ADDR_WDTH words; one read in flight, one write response outstanding.
module sort_circuit_mem
  import sort_circuit_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = DEF_ADDR_WDTH,
  parameter int unsigned DATA_WDTH = DEF_DATA_WDTH,
  parameter int unsigned RESP_WDTH = DEF_RESP_WDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 always_success,
  input  logic                 always_error,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_WDTH-1:0] ar_address,
  output logic                 r_valid,
  output logic [DATA_WDTH-1:0] r_data,
  output logic [RESP_WDTH-1:0] r_resp,
  input  logic                 aw_valid,
  output logic                 aw_ready,
  input  logic [ADDR_WDTH-1:0] aw_address,
  input  logic                 w_valid,
  input  logic [DATA_WDTH-1:0] w_data,
  output logic                 b_valid,
  input  logic                 b_ready,
  output logic [RESP_WDTH-1:0] b_resp
);

  logic [DATA_WDTH-1:0] mem [2**ADDR_WDTH];
  logic [RESP_WDTH-1:0] resp;
  logic                 rd_hs, wr_hs;

  // always_success wins if both overrides are set
  assign resp     = RESP_WDTH'(always_error && !always_success);
  assign ar_ready = !r_valid;
  assign aw_ready = !b_valid;
  assign rd_hs    = ar_valid && ar_ready;
  assign wr_hs    = aw_valid && w_valid && aw_ready;

  always_ff @(posedge clk) begin
    if (wr_hs) mem[aw_address] <= w_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= '0;
      b_valid <= 1'b0;
      b_resp  <= '0;
    end else begin
      // read data is a single-cycle pulse; the master has no r_ready
      r_valid <= rd_hs;
      if (rd_hs) begin
        r_data <= mem[ar_address];
        r_resp <= resp;
      end
      if (wr_hs) begin
        b_valid <= 1'b1;
        b_resp  <= resp;
      end else if (b_valid && b_ready) begin
        b_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sort_circuit.sv
// In-place ascending unsigned bubble sort of memory words 0..N-1 over a
// simple valid/ready bus.
// Ports: clk, rst_n (async, active low); arr_size/start request; done/err
// status; ar_*/r_* read channels; aw_*/w_* write channel; b_* response;
// swich_case_default flags an illegal state encoding.
module sort_circuit
  import sort_circuit_pkg::*;
#(
  parameter int unsigned ADDR_WDTH = DEF_ADDR_WDTH,
  parameter int unsigned DATA_WDTH = DEF_DATA_WDTH,
  parameter int unsigned RESP_WDTH = DEF_RESP_WDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic                 start,
  output logic                 done,
  output logic                 err,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [RESP_WDTH-1:0] b_resp,
  output logic                 swich_case_default
);

  localparam logic [ADDR_WDTH:0]   MaxN     = {1'b1, {ADDR_WDTH{1'b0}}};
  localparam logic [ADDR_WDTH:0]   IdxOne   = {{ADDR_WDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WDTH:0]   IdxTwo   = IdxOne + IdxOne;
  localparam logic [ADDR_WDTH-1:0] AddrOne  = {{(ADDR_WDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [ADDR_WDTH:0]   n_q, n_d;
  logic [ADDR_WDTH:0]   j_q, j_d;
  logic [ADDR_WDTH:0]   pass_q, pass_d;
  logic                 swapped_q, swapped_d;
  logic [DATA_WDTH-1:0] a_q, a_d, b_q, b_d;
  logic                 err_q, err_d;
  logic                 ar_valid_q, ar_valid_d;
  logic [ADDR_WDTH-1:0] ar_addr_q, ar_addr_d;
  logic                 aw_valid_q, aw_valid_d;
  logic [ADDR_WDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WDTH-1:0] w_data_q, w_data_d;
  logic [ADDR_WDTH:0]   last_j;
  logic [ADDR_WDTH-1:0] j_addr;

  // Index of the final pair compared in the current pass
  assign last_j = n_q - IdxTwo - pass_q;
  assign j_addr = j_q[ADDR_WDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      j_q        <= '0;
      pass_q     <= '0;
      swapped_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      err_q      <= 1'b0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      aw_valid_q <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      j_q        <= j_d;
      pass_q     <= pass_d;
      swapped_q  <= swapped_d;
      a_q        <= a_d;
      b_q        <= b_d;
      err_q      <= err_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      aw_valid_q <= aw_valid_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    n_d                = n_q;
    j_d                = j_q;
    pass_d             = pass_q;
    swapped_d          = swapped_q;
    a_d                = a_q;
    b_d                = b_q;
    err_d              = err_q;
    ar_valid_d         = ar_valid_q;
    ar_addr_d          = ar_addr_q;
    aw_valid_d         = aw_valid_q;
    aw_addr_d          = aw_addr_q;
    w_data_d           = w_data_q;
    swich_case_default = 1'b0;
    done               = 1'b0;
    b_ready            = 1'b0;

    case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (start) begin
          n_d = arr_size;
          if (arr_size <= IdxOne) begin
            state_d = StFin;
          end else if (arr_size > MaxN) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            j_d        = '0;
            pass_d     = '0;
            swapped_d  = 1'b0;
            ar_valid_d = 1'b1;
            ar_addr_d  = '0;
            state_d    = StRdA;
          end
        end
      end

      StRdA: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = StRdAWait;
        end
      end

      StRdAWait: begin
        if (r_valid) begin
          if (r_resp != '0) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            a_d        = r_data;
            ar_valid_d = 1'b1;
            ar_addr_d  = j_addr + AddrOne;
            state_d    = StRdB;
          end
        end
      end

      StRdB: begin
        if (ar_ready) begin
          ar_valid_d = 1'b0;
          state_d    = StRdBWait;
        end
      end

      StRdBWait: begin
        if (r_valid) begin
          if (r_resp != '0) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            b_d     = r_data;
            state_d = StCmp;
          end
        end
      end

      StCmp: begin
        if (a_q > b_q) begin
          aw_valid_d = 1'b1;
          aw_addr_d  = j_addr;
          w_data_d   = b_q;
          state_d    = StWrA;
        end else begin
          state_d = StNext;
        end
      end

      StWrA: begin
        if (aw_ready) begin
          aw_valid_d = 1'b0;
          state_d    = StWrAResp;
        end
      end

      StWrAResp: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_resp != '0) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            aw_valid_d = 1'b1;
            aw_addr_d  = j_addr + AddrOne;
            w_data_d   = a_q;
            state_d    = StWrB;
          end
        end
      end

      StWrB: begin
        if (aw_ready) begin
          aw_valid_d = 1'b0;
          state_d    = StWrBResp;
        end
      end

      StWrBResp: begin
        b_ready = 1'b1;
        if (b_valid) begin
          if (b_resp != '0) begin
            err_d   = 1'b1;
            state_d = StFin;
          end else begin
            swapped_d = 1'b1;
            state_d   = StNext;
          end
        end
      end

      StNext: begin
        if (j_q == last_j) begin
          // end of pass: stop early when nothing moved
          if (!swapped_q || pass_q == n_q - IdxTwo) begin
            state_d = StFin;
          end else begin
            pass_d     = pass_q + IdxOne;
            j_d        = '0;
            swapped_d  = 1'b0;
            ar_valid_d = 1'b1;
            ar_addr_d  = '0;
            state_d    = StRdA;
          end
        end else begin
          j_d        = j_q + IdxOne;
          ar_valid_d = 1'b1;
          ar_addr_d  = j_addr + AddrOne;
          state_d    = StRdA;
        end
      end

      StFin: begin
        done = 1'b1;
        if (!start) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end

      default: begin
        swich_case_default = 1'b1;
        err_d              = 1'b0;
        ar_valid_d         = 1'b0;
        aw_valid_d         = 1'b0;
        state_d            = StIdle;
      end
    endcase
  end

  assign err        = err_q;
  assign ar_valid   = ar_valid_q;
  assign ar_address = ar_addr_q;
  assign aw_valid   = aw_valid_q;
  assign w_valid    = aw_valid_q;
  assign aw_address = aw_addr_q;
  assign w_data     = w_data_q;

endmodule

// File: tb/tb_sort_circuit.sv
// Directed bench for sort_circuit with the companion memory model.
// The bench preloads memory through the write channel while the DUT is idle.
module tb_sort_circuit;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   arr_size = '0;
  logic          start = 1'b0;
  logic          done, err, swich_case_default;
  logic          ar_valid, ar_ready, r_valid;
  logic [AW-1:0] ar_address;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp, b_resp;
  logic          aw_valid, aw_ready, w_valid, b_valid, b_ready;
  logic [AW-1:0] aw_address;
  logic [DW-1:0] w_data;
  logic          always_success = 1'b0;
  logic          always_error = 1'b0;

  // bench-side loader, muxed onto the memory write channel
  logic          tb_mode = 1'b0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  logic          m_aw_valid, m_w_valid, m_b_ready;
  logic [AW-1:0] m_aw_address;
  logic [DW-1:0] m_w_data;

  assign m_aw_valid   = tb_mode ? ld_valid : aw_valid;
  assign m_w_valid    = tb_mode ? ld_valid : w_valid;
  assign m_aw_address = tb_mode ? ld_addr  : aw_address;
  assign m_w_data     = tb_mode ? ld_data  : w_data;
  assign m_b_ready    = tb_mode ? 1'b1     : b_ready;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ar_valid && ar_ready) rd_cnt <= rd_cnt + 1;
    if (!tb_mode && aw_valid && w_valid && aw_ready) wr_cnt <= wr_cnt + 1;
  end

  sort_circuit #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .arr_size(arr_size), .start(start),
    .done(done), .err(err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .swich_case_default(swich_case_default)
  );

  sort_circuit_mem #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) mem_i (
    .clk(clk), .rst_n(rst_n),
    .always_success(always_success), .always_error(always_error),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(m_aw_valid), .aw_ready(aw_ready), .aw_address(m_aw_address),
    .w_valid(m_w_valid), .w_data(m_w_data),
    .b_valid(b_valid), .b_ready(m_b_ready), .b_resp(b_resp)
  );

  task automatic load_word(input int addr, input int data);
    @(negedge clk);
    tb_mode  = 1'b1;
    ld_valid = 1'b1;
    ld_addr  = AW'(addr);
    ld_data  = DW'(data);
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    tb_mode  = 1'b0;
  endtask

  // Raise start and wait (bounded) for done; timeout is a failed check.
  task automatic run_sort(input int n, input bit poke_inputs);
    bit ok = 1'b0;
    @(negedge clk);
    arr_size = (AW+1)'(n);
    start    = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (poke_inputs && c == 4) arr_size = (AW+1)'(2);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL done_timeout n=%0d: done=%b required 1", n, done);
    end
  endtask

  // Done/err must hold while start stays high, then clear once start drops.
  task automatic release_start(input logic exp_err);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== exp_err) begin
      errors++;
      $display("FAIL fin_hold: done=%b err=%b required 1 %b", done, err, exp_err);
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL fin_return: done=%b err=%b required 0 0", done, err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({done, err, ar_valid, aw_valid, w_valid, b_ready, swich_case_default} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {done, err, ar_valid, aw_valid, w_valid, b_ready, swich_case_default});
    end
    checks++;
    if (ar_address !== '0 || aw_address !== '0 || w_data !== '0) begin
      errors++;
      $display("FAIL reset_bus: ar=%0d aw=%0d w=%0d required 0 0 0",
               ar_address, aw_address, w_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int init [4] = '{5, 3, 9, 1};
    int exp  [4] = '{1, 3, 5, 9};
    for (int i = 0; i < 4; i++) load_word(i, init[i]);
    run_sort(4, 1'b1);  // arr_size changes mid-sort must be ignored
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err: err=%b required 0", err);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_i.mem[i] !== DW'(exp[i])) begin
        errors++;
        $display("FAIL basic_mem[%0d]: got %0d required %0d", i, mem_i.mem[i], exp[i]);
      end
    end
    release_start(1'b0);
  endtask

  task automatic test_sorted();
    int r0, w0;
    for (int i = 0; i < 4; i++) load_word(i, i + 1);
    r0 = rd_cnt;
    w0 = wr_cnt;
    run_sort(4, 1'b0);
    // one pass over 3 pairs, two reads each
    checks++;
    if (wr_cnt - w0 != 0 || rd_cnt - r0 != 6 || err !== 1'b0) begin
      errors++;
      $display("FAIL sorted_traffic: writes=%0d reads=%0d err=%b required 0 6 0",
               wr_cnt - w0, rd_cnt - r0, err);
    end
    release_start(1'b0);
  endtask

  task automatic test_desc16();
    int bad = 0;
    for (int i = 0; i < 16; i++) load_word(i, 15 - i);
    run_sort(16, 1'b0);
    for (int i = 0; i < 16; i++) if (mem_i.mem[i] !== DW'(i)) bad++;
    checks++;
    if (bad != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL desc16: wrong_words=%0d err=%b required 0 0", bad, err);
    end
    release_start(1'b0);
  endtask

  task automatic test_error();
    int r0, w0;
    for (int i = 0; i < 4; i++) load_word(i, 4 - i);
    always_error = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    run_sort(4, 1'b0);
    checks++;
    if (err !== 1'b1 || rd_cnt - r0 != 1 || wr_cnt - w0 != 0) begin
      errors++;
      $display("FAIL error_abort: err=%b reads=%0d writes=%0d required 1 1 0",
               err, rd_cnt - r0, wr_cnt - w0);
    end
    release_start(1'b1);
    always_error = 1'b0;
  endtask

  task automatic test_sizes();
    int ns   [3] = '{0, 1, 17};
    logic es [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      int r0 = rd_cnt;
      run_sort(ns[k], 1'b0);
      checks++;
      if (err !== es[k] || rd_cnt != r0) begin
        errors++;
        $display("FAIL size_n%0d: err=%b reads=%0d required %b 0",
                 ns[k], err, rd_cnt - r0, es[k]);
      end
      release_start(es[k]);
    end
  endtask

  task automatic test_mid_reset();
    int exp [4] = '{1, 2, 3, 4};
    for (int i = 0; i < 16; i++) load_word(i, 15 - i);
    @(negedge clk);
    arr_size = 5'd16;
    start    = 1'b1;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({done, err, ar_valid, aw_valid, w_valid, b_ready, swich_case_default} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b required 0000000",
               {done, err, ar_valid, aw_valid, w_valid, b_ready, swich_case_default});
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_word(0, 4);
    load_word(1, 2);
    load_word(2, 3);
    load_word(3, 1);
    run_sort(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_i.mem[i] !== DW'(exp[i])) begin
        errors++;
        $display("FAIL midreset_mem[%0d]: got %0d required %0d", i, mem_i.mem[i], exp[i]);
      end
    end
    release_start(1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sorted();
    test_desc16();
    test_error();
    test_sizes();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
